// File: rtl/boreal_mbx_dispatcher_if.sv
// Mailbox direct-read port plus the outbound message stream of boreal_mbx_dispatcher.
// master = dispatcher side; slave = mailbox and downstream ingest FIFO side.
interface boreal_mbx_dispatcher_if;
    logic        mb_slot0_valid;
    logic        mb_slot1_valid;
    logic        mb_rd_slot;
    logic [3:0]  mb_rd_idx;
    logic [31:0] mb_rd_data;
    logic        mb_slot0_ack;
    logic        mb_slot1_ack;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_slot;
    logic [3:0]  out_idx;
    logic        out_last;

    modport master (
        input  mb_slot0_valid, mb_slot1_valid, mb_rd_data, out_ready,
        output mb_rd_slot, mb_rd_idx, mb_slot0_ack, mb_slot1_ack,
               out_valid, out_data, out_slot, out_idx, out_last
    );

    modport slave (
        output mb_slot0_valid, mb_slot1_valid, mb_rd_data, out_ready,
        input  mb_rd_slot, mb_rd_idx, mb_slot0_ack, mb_slot1_ack,
               out_valid, out_data, out_slot, out_idx, out_last
    );
endinterface

// File: rtl/boreal_mbx_dispatcher.sv
// Drains the two AI-mailbox slots into the VM ingest stream, one 16-word message at a time.
// Optional stall-timeout message drop is enabled by defining MBX_DISP_TIMEOUT_EN.
module boreal_mbx_dispatcher #(
    parameter int WORDS       = 16,
    parameter int CNT_W       = 16,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    boreal_mbx_dispatcher_if.master bus,
    output logic                    busy,
    output logic [CNT_W-1:0]        msg_count,
    output logic                    err_drop
);

    localparam logic [4:0] LOAD_MAX = 5'(WORDS);
    localparam logic [3:0] LAST_IDX = 4'(WORDS - 1);

    if (WORDS < 1 || WORDS > 16) begin : g_bad_words
        $error("boreal_mbx_dispatcher: WORDS must be within 1..16");
    end
    if (TIMEOUT_CYC < 2) begin : g_bad_timeout
        $error("boreal_mbx_dispatcher: TIMEOUT_CYC must be at least 2");
    end

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        ACK    = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nx;
    logic        cur_slot;
    logic        last_served;
    logic [3:0]  rd_ptr;
    logic [4:0]  loaded;
    logic        out_valid;
    logic [31:0] out_data;
    logic [3:0]  out_idx;
    logic        grant;
    logic        grant_slot;
    logic        accept;
    logic        finish;
    logic        load;
    logic        timeout;
    logic        count_msg;

`ifdef MBX_DISP_TIMEOUT_EN
    localparam int STALL_W = $clog2(TIMEOUT_CYC) + 1;

    logic [STALL_W-1:0] stall_cnt;
    logic               dropped;
    logic               err_drop_q;

    assign timeout = (state == STREAM) && out_valid && !bus.out_ready &&
                     (stall_cnt == STALL_W'(TIMEOUT_CYC - 1));

    // Stall run length of the current beat; dropped remembers that the ACK is a discard.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt  <= '0;
            dropped    <= 1'b0;
            err_drop_q <= 1'b0;
        end else begin
            if (state != STREAM || accept) begin
                stall_cnt <= '0;
            end else if (out_valid && !bus.out_ready) begin
                stall_cnt <= stall_cnt + STALL_W'(1);
            end
            if (timeout) begin
                dropped    <= 1'b1;
                err_drop_q <= 1'b1;
            end else if (grant) begin
                dropped <= 1'b0;
            end
        end
    end

    assign count_msg = !dropped;
    assign err_drop  = err_drop_q;
`else
    assign timeout   = 1'b0;
    assign count_msg = 1'b1;
    assign err_drop  = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Both slots pending: serve the one not served last, so neither slot starves.
    always_comb begin
        state_nx   = state;
        grant      = 1'b0;
        grant_slot = 1'b0;
        load       = 1'b0;
        accept     = out_valid && bus.out_ready;
        finish     = accept && (out_idx == LAST_IDX);
        case (state)
            IDLE: begin
                if (enable && (bus.mb_slot0_valid || bus.mb_slot1_valid)) begin
                    grant      = 1'b1;
                    grant_slot = (bus.mb_slot0_valid && bus.mb_slot1_valid) ?
                                 ~last_served : bus.mb_slot1_valid;
                    state_nx   = STREAM;
                end
            end
            STREAM: begin
                if (finish || timeout) begin
                    state_nx = ACK;
                end else begin
                    load = (loaded < LOAD_MAX) && (!out_valid || bus.out_ready);
                end
            end
            ACK: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Output register doubles as the skid stage: a beat is only replaced once accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_slot    <= 1'b0;
            last_served <= 1'b1;
            rd_ptr      <= 4'd0;
            loaded      <= 5'd0;
            out_valid   <= 1'b0;
            out_data    <= 32'd0;
            out_idx     <= 4'd0;
            msg_count   <= '0;
        end else begin
            if (grant) begin
                cur_slot <= grant_slot;
                rd_ptr   <= 4'd0;
                loaded   <= 5'd0;
            end
            if (load) begin
                out_data  <= bus.mb_rd_data;
                out_idx   <= rd_ptr;
                out_valid <= 1'b1;
                rd_ptr    <= rd_ptr + 4'd1;
                loaded    <= loaded + 5'd1;
            end else if (accept || timeout) begin
                out_valid <= 1'b0;
            end
            if (state == ACK) begin
                last_served <= cur_slot;
                if (count_msg) begin
                    msg_count <= msg_count + CNT_W'(1);
                end
            end
        end
    end

    assign bus.mb_rd_slot   = cur_slot;
    assign bus.mb_rd_idx    = rd_ptr;
    assign bus.mb_slot0_ack = (state == ACK) && !cur_slot;
    assign bus.mb_slot1_ack = (state == ACK) && cur_slot;
    assign bus.out_valid    = out_valid;
    assign bus.out_data     = out_data;
    assign bus.out_slot     = cur_slot;
    assign bus.out_idx      = out_idx;
    assign bus.out_last     = (out_idx == LAST_IDX);
    assign busy             = (state != IDLE);

endmodule
